// File: rtl/mul_pkg.sv
// mul_pkg: constants and types shared by the multiplier and its product accumulator
package mul_pkg;
    localparam int PROD_W = 8;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_e;
endpackage

// File: rtl/product_block_accumulator.sv
// product_block_accumulator: sums blocks of BLK_LEN products into a valid/ready result register
module product_block_accumulator #(
    parameter int PROD_W  = mul_pkg::PROD_W,
    parameter int BLK_LEN = 4,
    parameter int ACC_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);
    import mul_pkg::*;

    localparam int CW = BLK_LEN > 1 ? $clog2(BLK_LEN) : 1;
    localparam int SW = ACC_W + 1;

    if (BLK_LEN < 1 || ACC_W < PROD_W) begin : g_bad_params
        $error("product_block_accumulator: need BLK_LEN>=1 and ACC_W>=PROD_W");
    end

    acc_state_e       state, state_d;
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             ovf_acc;
    logic [ACC_W:0]   sum;
    logic             accept, last;

    assign in_ready = state != HOLD;
    assign busy     = state == ACCUM;
    assign accept   = in_valid & in_ready;
    assign last     = cnt == CW'(BLK_LEN - 1);
    // top bit of sum is the carry out of the ACC_W-bit accumulator
    assign sum      = {1'b0, acc} + SW'(in_prod);

    always_comb begin
        state_d = state;
        if (clr) state_d = IDLE;
        else if (state == HOLD) state_d = out_ready ? IDLE : HOLD;
        else if (accept) state_d = last ? HOLD : ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept && last) begin
            out_sum   <= sum[ACC_W-1:0];
            out_ovf   <= ovf_acc | sum[ACC_W];
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
        end else if (accept) begin
            acc     <= sum[ACC_W-1:0];
            cnt     <= cnt + CW'(1);
            ovf_acc <= ovf_acc | sum[ACC_W];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_product_block_accumulator.sv
// tb_product_block_accumulator: random and directed checks of two accumulator widths against an integer-sum model
module tb_product_block_accumulator;
    localparam int BLK = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_prod = '0;
    logic       out_ready = 1'b1;

    logic       ir0, ov0, of0, bz0, ir1, ov1, of1, bz1;
    logic [9:0] s0;
    logic [7:0] s1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    product_block_accumulator #(.PROD_W(8), .BLK_LEN(BLK), .ACC_W(10)) d0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir0),
        .in_prod(in_prod), .out_valid(ov0), .out_ready(out_ready), .out_sum(s0),
        .out_ovf(of0), .busy(bz0));

    product_block_accumulator #(.PROD_W(8), .BLK_LEN(BLK), .ACC_W(8)) d1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir1),
        .in_prod(in_prod), .out_valid(ov1), .out_ready(out_ready), .out_sum(s1),
        .out_ovf(of1), .busy(bz1));

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: integer running total of the current block; wrap and overflow derived at the output
    int m_n, m_sum, m_tot;
    bit m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0; m_sum <= 0; m_pend <= 0; m_tot <= 0;
        end else if (clr) begin
            m_n <= 0; m_sum <= 0; m_pend <= 0;
        end else if (m_pend) begin
            if (out_ready) m_pend <= 0;
        end else if (in_valid) begin
            if (m_n == BLK - 1) begin
                m_pend <= 1; m_tot <= m_sum + int'(in_prod); m_n <= 0; m_sum <= 0;
            end else begin
                m_n <= m_n + 1; m_sum <= m_sum + int'(in_prod);
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready0", int'(ir0), int'(!m_pend));
        chk("in_ready1", int'(ir1), int'(!m_pend));
        chk("busy0", int'(bz0), int'(m_n > 0));
        chk("busy1", int'(bz1), int'(m_n > 0));
        chk("out_valid0", int'(ov0), int'(m_pend));
        chk("out_valid1", int'(ov1), int'(m_pend));
        if (m_pend) begin
            chk("out_sum0", int'(s0), m_tot % 1024);
            chk("out_ovf0", int'(of0), int'(m_tot >= 1024));
            chk("out_sum1", int'(s1), m_tot % 256);
            chk("out_ovf1", int'(of1), int'(m_tot >= 256));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(int p);
        int k = 0;
        in_valid = 1'b1;
        in_prod = 8'(p);
        while (!ir0 && k < 20) begin step(); k++; end
        if (k == 20) chk("beat_timeout", 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic wait_res(string nm, int e0, int o0, int e1, int o1);
        int k = 0;
        while (!ov0 && k < 20) begin step(); k++; end
        chk({nm, "_valid"}, int'(ov0), 1);
        chk({nm, "_sum0"}, int'(s0), e0);
        chk({nm, "_ovf0"}, int'(of0), o0);
        chk({nm, "_sum1"}, int'(s1), e1);
        chk({nm, "_ovf1"}, int'(of1), o1);
    endtask

    initial begin
        #12 rst_n = 1'b1;
        step();
        // 1: reset mid-block
        beat(7); beat(9);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", int'(ov0), 0);
        chk("rst_sum", int'(s0), 0);
        chk("rst_busy", int'(bz0), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", int'(ir0), 1);
        repeat (4) beat(1);
        wait_res("t1", 4, 0, 4, 0);
        // 2: back-to-back block
        beat(10); beat(20); beat(30); beat(40);
        wait_res("t2", 100, 0, 100, 0);
        chk("t2_in_ready", int'(ir0), 0);
        step();
        chk("t2_valid_drop", int'(ov0), 0);
        // 3: largest products
        repeat (4) beat(225);
        wait_res("t3", 900, 0, 132, 1);
        step();
        // 4: backpressure with in_valid held high
        out_ready = 1'b0;
        beat(10); beat(20); beat(30); beat(40);
        in_valid = 1'b1; in_prod = 8'd99;
        wait_res("t4", 100, 0, 100, 0);
        repeat (5) begin
            step();
            chk("t4_hold_valid", int'(ov0), 1);
            chk("t4_hold_sum", int'(s0), 100);
            chk("t4_hold_ready", int'(ir0), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        beat(1); beat(2); beat(3); beat(4);
        wait_res("t4b", 10, 0, 10, 0);
        step();
        // 5: narrow accumulator wraps
        beat(200); beat(100); beat(0); beat(0);
        wait_res("t5", 300, 0, 44, 1);
        step();
        repeat (4) beat(1);
        wait_res("t5b", 4, 0, 4, 0);
        step();
        // 6: clear drops partial and a coincident beat; bubbles; clear in HOLD
        out_ready = 1'b0;
        beat(5); beat(5);
        clr = 1'b1; in_valid = 1'b1; in_prod = 8'd77;
        step();
        clr = 1'b0; in_valid = 1'b0;
        chk("t6_clr_busy", int'(bz0), 0);
        beat(1); idle(2); beat(2); idle(1); beat(3); idle(3); beat(4);
        wait_res("t6", 10, 0, 10, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t6_clr_hold", int'(ov0), 0);
        chk("t6_clr_ready", int'(ir0), 1);
        out_ready = 1'b1;
        // random traffic, checked each cycle by the model
        repeat (3000) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_prod = 8'($urandom);
            out_ready = 1'($urandom_range(0, 2) != 0);
            clr = 1'($urandom_range(0, 39) == 0);
            step();
        end
        clr = 1'b0; in_valid = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
